decode_issue: RTL and testbench
===============================

// Module: decode_issue
// PURPOSE
//  Decode/issue stage directly upstream of regfile. Takes fetched 32-bit RV32I instructions, drives regfile
//  read addresses, captures operands into a registered ID/EX output with valid/ready handshake.
//  Keeps a 32-entry busy scoreboard of pending rd writes, stalls on RAW hazards, bypasses same-cycle writeback data.
// PARAMETERS
//  DATA_WIDTH   32  operand/instruction width
//  ADDR_WIDTH   5   register address width (32 registers, x0 hardwired zero)
// PORTS
//  clock           in   1   single clock, all state updates on rising edge
//  reset           in   1   synchronous, active-low; sampled on rising edge of clock
//  instr           in   32  instruction word from fetch
//  instr_valid     in   1   instr is valid
//  instr_ready     out  1   stage accepts instr this cycle
//  address_read_1  out  5   regfile read port 1 address (= instr[19:15])
//  address_read_2  out  5   regfile read port 2 address (= instr[24:20])
//  read_data_1     in   32  regfile read port 1 data (combinational)
//  read_data_2     in   32  regfile read port 2 data (combinational)
//  wb_valid        in   1   writeback retiring a register write this cycle
//  wb_rd           in   5   writeback destination
//  wb_data         in   32  writeback data (reaches regfile only at this clock edge)
//  ex_valid        out  1   ID/EX register holds an issued instruction
//  ex_ready        in   1   execute consumes ID/EX contents this cycle
//  ex_opcode/ex_funct3/ex_funct7  out 7/3/7  decoded fields
//  ex_rd           out  5   destination (0 if no write)
//  ex_rs1_data     out  32  operand 1 (bypassed)
//  ex_rs2_data     out  32  operand 2 (bypassed)
//  ex_imm          out  32  sign-extended immediate per format
// BEHAVIOUR
//  Reset (reset==0 at edge): ex_valid=0, every ex_* data output=0, busy[31:0]=0. Mid-operation reset discards the held instruction and pending busy bits.
//  Address outputs combinational from instr regardless of instr_valid.
//  uses_rs1: all opcodes except LUI, AUIPC, JAL. uses_rs2: OP, STORE, BRANCH.
//  writes_rd: OP, OP-IMM, LOAD, LUI, AUIPC, JAL, JALR, and rd!=0; else ex_rd=0.
//  bypass_n = wb_valid && wb_rd==rs_n && rs_n!=0; operand = bypass ? wb_data : (rs_n==0 ? 0 : read_data_n).
//  hazard = (uses_rs1 && busy[rs1] && !bypass_1) || (uses_rs2 && busy[rs2] && !bypass_2).
//  instr_ready = !hazard && (!ex_valid || ex_ready); accept = instr_valid && instr_ready.
//  ID/EX states EMPTY(ex_valid=0)/FULL(ex_valid=1):
//   accept -> FULL, load all ex_* fields (1-cycle latency, issue to ex_valid);
//   FULL && ex_ready && !accept -> EMPTY; FULL && !ex_ready -> hold every ex_* output stable.
//  Scoreboard per register r: clear on wb_valid&&wb_rd==r; set on accept&&writes_rd&&rd==r;
//   set and clear same r same cycle -> set wins (bit stays 1). busy[0] always 0.
//  Instruction whose own rs equals its rd (e.g. addi x5,x5,1) checks hazard before its own set.
//  Back-to-back dependent instructions: second stalls until wb of first; at that wb cycle bypass issues it.
//  wb_valid with wb_rd not busy: no effect beyond bypass. Unknown opcode: issued, writes_rd=0, imm=0.
// STRUCTURE
//  Shared header cpu_defs.vh: opcode localparams (OP, OP_IMM, LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR),
//   field bit ranges, XLEN/register-count constants; reused by regfile and execute.
//  One sub-module: imm_gen (combinational, instr -> 32-bit immediate for I/S/B/U/J formats).
//  Scoreboard and ID/EX register inline.
// TESTING
//  1 Regfile preloaded xi=i+100; issue add x3,x1,x2 with ex_ready=1 -> next cycle ex_valid=1, rs1=101, rs2=102, ex_rd=3.
//  2 addi x4,x3,5 right after add x3 -> instr_ready=0 until wb_valid,wb_rd=3,wb_data=203; that cycle
//    accepted, ex_rs1_data=203, ex_imm=5; busy[3]=0, busy[4]=1 afterward.
//  3 ex_ready=0 for 3 cycles with ex_valid=1 -> ex_* unchanged, instr_ready=0; ex_ready=1 -> drains, next instr accepted same cycle.
//  4 addi x0,x0,7 then add x1,x0,x0 -> no stall, busy[0]=0, ex_rd=0 for first, operands 0 for second.
//  5 wb of x5 coincident with issue of lui x5,0x12345 -> busy[5]=1 after edge, ex_imm=0x12345000.
//  6 reset low for one edge while FULL with busy[7]=1 -> ex_valid=0, busy=0, instr_ready=1 next cycle.

Source files
------------

// File: rtl/decode_issue_pkg.sv
`default_nettype none
// decode_issue_pkg: RV32I opcodes, instruction field positions and the
// decode helper shared by the decode/issue stage.
package decode_issue_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;

  localparam int OPCODE_LSB = 0;
  localparam int RD_LSB     = 7;
  localparam int FUNCT3_LSB = 12;
  localparam int RS1_LSB    = 15;
  localparam int RS2_LSB    = 20;
  localparam int FUNCT7_LSB = 25;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic {
    IDEX_EMPTY = 1'b0,
    IDEX_FULL  = 1'b1
  } idex_state_e;

  typedef struct packed {
    logic uses_rs1;
    logic uses_rs2;
    logic writes_rd;
  } dec_ctl_t;

  function automatic dec_ctl_t decode_ctl(input logic [6:0] opc, input logic [4:0] rd);
    dec_ctl_t c;
    c.uses_rs1  = !(opc == OPC_LUI || opc == OPC_AUIPC || opc == OPC_JAL);
    c.uses_rs2  = (opc == OPC_OP || opc == OPC_STORE || opc == OPC_BRANCH);
    c.writes_rd = (rd != 5'd0) &&
                  (opc inside {OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_LUI,
                               OPC_AUIPC, OPC_JAL, OPC_JALR});
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/decode_issue_imm_gen.sv
`default_nettype none
// decode_issue_imm_gen: sign-extended immediate for I/S/B/U/J formats;
// R-type and unrecognised opcodes yield zero.
module decode_issue_imm_gen
  import decode_issue_pkg::*;
(
  input  logic [XLEN-1:0] instr_i,
  output logic [XLEN-1:0] imm_o
);

  always_comb begin
    imm_o = '0;
    case (instr_i[OPCODE_LSB +: 7])
      OPC_OP_IMM, OPC_LOAD, OPC_JALR:
        imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
      OPC_STORE:
        imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      OPC_BRANCH:
        imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                 instr_i[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        imm_o = {instr_i[31:12], 12'b0};
      OPC_JAL:
        imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                 instr_i[30:21], 1'b0};
      default:
        imm_o = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/decode_issue.sv
`default_nettype none
// decode_issue: RV32I decode/issue stage with busy-bit scoreboard, writeback
// bypass and a single-entry ID/EX register with valid/ready handshake.
module decode_issue
  import decode_issue_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] instr,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  output logic [ADDR_WIDTH-1:0] address_read_1,
  output logic [ADDR_WIDTH-1:0] address_read_2,
  input  logic [DATA_WIDTH-1:0] read_data_1,
  input  logic [DATA_WIDTH-1:0] read_data_2,
  input  logic                  wb_valid,
  input  logic [ADDR_WIDTH-1:0] wb_rd,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic                  ex_valid,
  input  logic                  ex_ready,
  output logic [6:0]            ex_opcode,
  output logic [2:0]            ex_funct3,
  output logic [6:0]            ex_funct7,
  output logic [ADDR_WIDTH-1:0] ex_rd,
  output logic [DATA_WIDTH-1:0] ex_rs1_data,
  output logic [DATA_WIDTH-1:0] ex_rs2_data,
  output logic [DATA_WIDTH-1:0] ex_imm
);

  localparam int NUM_REGS = 1 << ADDR_WIDTH;

  idex_state_e           state_q;
  logic [NUM_REGS-1:0]   busy_q;
  logic [NUM_REGS-1:0]   busy_d;

  logic [6:0]            opcode;
  logic [ADDR_WIDTH-1:0] rs1, rs2, rd;
  dec_ctl_t              ctl;
  logic                  bypass_1, bypass_2;
  logic [DATA_WIDTH-1:0] operand_1, operand_2, imm;
  logic                  hazard, accept;

  assign opcode = instr[OPCODE_LSB +: 7];
  assign rd     = instr[RD_LSB  +: ADDR_WIDTH];
  assign rs1    = instr[RS1_LSB +: ADDR_WIDTH];
  assign rs2    = instr[RS2_LSB +: ADDR_WIDTH];
  assign ctl    = decode_ctl(opcode, rd);

  assign address_read_1 = rs1;
  assign address_read_2 = rs2;

  decode_issue_imm_gen u_imm_gen (
    .instr_i (instr),
    .imm_o   (imm)
  );

  // wb_data lands in the regfile only at this edge, so forward it directly.
  assign bypass_1  = wb_valid && (wb_rd == rs1) && (rs1 != '0);
  assign bypass_2  = wb_valid && (wb_rd == rs2) && (rs2 != '0);
  assign operand_1 = bypass_1 ? wb_data : ((rs1 == '0) ? '0 : read_data_1);
  assign operand_2 = bypass_2 ? wb_data : ((rs2 == '0) ? '0 : read_data_2);

  // Hazard uses busy_q, so an instruction never stalls on its own rd.
  assign hazard = (ctl.uses_rs1 && busy_q[rs1] && !bypass_1) ||
                  (ctl.uses_rs2 && busy_q[rs2] && !bypass_2);

  assign ex_valid    = (state_q == IDEX_FULL);
  assign instr_ready = !hazard && (!ex_valid || ex_ready);
  assign accept      = instr_valid && instr_ready;

  always_comb begin
    busy_d = busy_q;
    if (wb_valid)
      busy_d[wb_rd] = 1'b0;
    if (accept && ctl.writes_rd)
      busy_d[rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDEX_EMPTY;
      busy_q      <= '0;
      ex_opcode   <= '0;
      ex_funct3   <= '0;
      ex_funct7   <= '0;
      ex_rd       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
    end else begin
      busy_q <= busy_d;
      if (accept) begin
        state_q     <= IDEX_FULL;
        ex_opcode   <= opcode;
        ex_funct3   <= instr[FUNCT3_LSB +: 3];
        ex_funct7   <= instr[FUNCT7_LSB +: 7];
        ex_rd       <= ctl.writes_rd ? rd : '0;
        ex_rs1_data <= operand_1;
        ex_rs2_data <= operand_2;
        ex_imm      <= imm;
      end else if (state_q == IDEX_FULL && ex_ready) begin
        state_q <= IDEX_EMPTY;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_decode_issue.sv
`default_nettype none
// tb_decode_issue: directed scenarios followed by randomized traffic, all
// checked against an instruction-level reference model of the stage.
module tb_decode_issue;

  localparam logic [6:0] T_OP     = 7'b0110011;
  localparam logic [6:0] T_OPIMM  = 7'b0010011;
  localparam logic [6:0] T_LOAD   = 7'b0000011;
  localparam logic [6:0] T_STORE  = 7'b0100011;
  localparam logic [6:0] T_BRANCH = 7'b1100011;
  localparam logic [6:0] T_LUI    = 7'b0110111;
  localparam logic [6:0] T_AUIPC  = 7'b0010111;
  localparam logic [6:0] T_JAL    = 7'b1101111;
  localparam logic [6:0] T_JALR   = 7'b1100111;
  localparam logic [6:0] T_CUSTOM = 7'b0001011;

  typedef struct packed {
    logic        u1;
    logic        u2;
    logic        wr;
    logic [31:0] imm;
  } ref_dec_t;

  logic        clock = 1'b0;
  logic        reset, instr_valid, instr_ready, wb_valid, ex_valid, ex_ready;
  logic [31:0] instr, read_data_1, read_data_2, wb_data, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  address_read_1, address_read_2, wb_rd, ex_rd;
  logic [6:0]  ex_opcode, ex_funct7;
  logic [2:0]  ex_funct3;

  logic        preload;
  logic [31:0] rf [32];

  int n_assert = 0;
  int n_fail   = 0;

  logic        m_valid, m_zero, last_ready;
  logic [31:0] m_busy;
  logic [6:0]  m_opcode, m_funct7;
  logic [2:0]  m_funct3;
  logic [4:0]  m_rd;
  logic [31:0] m_rs1, m_rs2, m_imm;

  decode_issue dut (
    .clock          (clock),
    .reset          (reset),
    .instr          (instr),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .address_read_1 (address_read_1),
    .address_read_2 (address_read_2),
    .read_data_1    (read_data_1),
    .read_data_2    (read_data_2),
    .wb_valid       (wb_valid),
    .wb_rd          (wb_rd),
    .wb_data        (wb_data),
    .ex_valid       (ex_valid),
    .ex_ready       (ex_ready),
    .ex_opcode      (ex_opcode),
    .ex_funct3      (ex_funct3),
    .ex_funct7      (ex_funct7),
    .ex_rd          (ex_rd),
    .ex_rs1_data    (ex_rs1_data),
    .ex_rs2_data    (ex_rs2_data),
    .ex_imm         (ex_imm)
  );

  always #5 clock = ~clock;

  // Regfile model; x0 deliberately returns non-zero so the stage must mask it.
  always @(posedge clock) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'(i + 100);
    end else if (wb_valid && wb_rd != 5'd0) begin
      rf[wb_rd] <= wb_data;
    end
  end
  assign read_data_1 = rf[address_read_1];
  assign read_data_2 = rf[address_read_2];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic ref_dec_t decode_ref(input logic [31:0] w);
    ref_dec_t r;
    int sw;
    sw = int'(w);
    r.u1 = 1'b1; r.u2 = 1'b0; r.wr = 1'b0; r.imm = 32'd0;
    case (w[6:0])
      T_OP:                     begin r.u2 = 1'b1; r.wr = 1'b1; end
      T_OPIMM, T_LOAD, T_JALR:  begin r.wr = 1'b1; r.imm = 32'(sw >>> 20); end
      T_STORE:  begin r.u2 = 1'b1; r.imm = 32'((sw >>> 25) * 32 + ((sw >> 7) & 31)); end
      T_BRANCH: begin
        r.u2 = 1'b1;
        r.imm = 32'((sw >>> 31) * 4096 + ((sw >> 7) & 1) * 2048 +
                    ((sw >> 25) & 63) * 32 + ((sw >> 8) & 15) * 2);
      end
      T_LUI, T_AUIPC: begin r.u1 = 1'b0; r.wr = 1'b1; r.imm = w & 32'hFFFFF000; end
      T_JAL: begin
        r.u1 = 1'b0; r.wr = 1'b1;
        r.imm = 32'((sw >>> 31) * (1 << 20) + ((sw >> 12) & 255) * 4096 +
                    ((sw >> 20) & 1) * 2048 + ((sw >> 21) & 1023) * 2);
      end
      default: ;
    endcase
    if (w[11:7] == 5'd0) r.wr = 1'b0;
    return r;
  endfunction

  function automatic logic [31:0] r_ins(input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [4:0] rd);
    return {7'd0, rs2, rs1, 3'd0, rd, T_OP};
  endfunction

  function automatic logic [31:0] i_ins(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [4:0] rd);
    return {imm, rs1, 3'd0, rd, T_OPIMM};
  endfunction

  // One clock: check combinational outputs, advance model at the edge, check registers.
  task automatic cycle();
    ref_dec_t    d;
    logic [4:0]  s1, s2, rd;
    logic        b1, b2, rdy, acc;
    logic [31:0] op1, op2, nb;
    #1;
    s1 = instr[19:15]; s2 = instr[24:20]; rd = instr[11:7];
    d  = decode_ref(instr);
    b1 = wb_valid && (wb_rd == s1) && (s1 != 5'd0);
    b2 = wb_valid && (wb_rd == s2) && (s2 != 5'd0);
    op1 = b1 ? wb_data : ((s1 == 5'd0) ? 32'd0 : rf[s1]);
    op2 = b2 ? wb_data : ((s2 == 5'd0) ? 32'd0 : rf[s2]);
    rdy = !((d.u1 && m_busy[s1] && !b1) || (d.u2 && m_busy[s2] && !b2)) &&
          (!m_valid || ex_ready);
    last_ready = instr_ready;
    chk("instr_ready", 32'(instr_ready), 32'(rdy));
    chk("address_read_1", 32'(address_read_1), 32'(s1));
    chk("address_read_2", 32'(address_read_2), 32'(s2));
    acc = instr_valid && rdy;
    @(posedge clock);
    if (!reset) begin
      m_valid = 1'b0; m_zero = 1'b1; m_busy = 32'd0;
      m_opcode = '0; m_funct3 = '0; m_funct7 = '0; m_rd = '0;
      m_rs1 = '0; m_rs2 = '0; m_imm = '0;
    end else begin
      nb = m_busy;
      if (wb_valid) nb[wb_rd] = 1'b0;
      if (acc && d.wr) nb[rd] = 1'b1;
      nb[0] = 1'b0;
      m_busy = nb;
      if (acc) begin
        m_valid = 1'b1; m_zero = 1'b0;
        m_opcode = instr[6:0]; m_funct3 = instr[14:12]; m_funct7 = instr[31:25];
        m_rd = d.wr ? rd : 5'd0;
        m_rs1 = op1; m_rs2 = op2; m_imm = d.imm;
      end else if (m_valid && ex_ready) begin
        m_valid = 1'b0;
      end
    end
    #1;
    chk("ex_valid", 32'(ex_valid), 32'(m_valid));
    chk("busy", dut.busy_q, m_busy);
    if (m_valid || m_zero) begin
      chk("ex_opcode", 32'(ex_opcode), 32'(m_opcode));
      chk("ex_funct3", 32'(ex_funct3), 32'(m_funct3));
      chk("ex_funct7", 32'(ex_funct7), 32'(m_funct7));
      chk("ex_rd", 32'(ex_rd), 32'(m_rd));
      chk("ex_rs1_data", ex_rs1_data, m_rs1);
      chk("ex_rs2_data", ex_rs2_data, m_rs2);
      chk("ex_imm", ex_imm, m_imm);
    end
  endtask

  function automatic logic [6:0] pick_op(input int n);
    case (n)
      0: return T_OP;     1: return T_OPIMM; 2: return T_LOAD;  3: return T_STORE;
      4: return T_BRANCH; 5: return T_LUI;   6: return T_AUIPC; 7: return T_JAL;
      8: return T_JALR;   default: return T_CUSTOM;
    endcase
  endfunction

  initial begin
    logic [4:0]  busy_list [$];
    logic [31:0] w;

    m_valid = 1'b0; m_zero = 1'b0; m_busy = 32'd0;
    m_opcode = '0; m_funct3 = '0; m_funct7 = '0; m_rd = '0;
    m_rs1 = '0; m_rs2 = '0; m_imm = '0;
    reset = 1'b0; preload = 1'b1; instr = 32'd0; instr_valid = 1'b0;
    ex_ready = 1'b1; wb_valid = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;

    // Reset with regfile preload
    cycle();
    preload = 1'b0;
    cycle();
    chk("reset ex_valid", 32'(ex_valid), 32'd0);
    chk("reset ex_imm", ex_imm, 32'd0);
    chk("reset busy", dut.busy_q, 32'd0);
    reset = 1'b1;

    // add x3,x1,x2
    instr = r_ins(5'd2, 5'd1, 5'd3); instr_valid = 1'b1;
    cycle();
    chk("t1 ex_valid", 32'(ex_valid), 32'd1);
    chk("t1 rs1", ex_rs1_data, 32'd101);
    chk("t1 rs2", ex_rs2_data, 32'd102);
    chk("t1 rd", 32'(ex_rd), 32'd3);

    // addi x4,x3,5 stalls until x3 writes back, then issues via bypass
    instr = i_ins(12'd5, 5'd3, 5'd4);
    cycle();
    chk("t2 stall a", 32'(last_ready), 32'd0);
    cycle();
    chk("t2 stall b", 32'(last_ready), 32'd0);
    wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'd203;
    cycle();
    chk("t2 accept", 32'(last_ready), 32'd1);
    chk("t2 rs1 bypass", ex_rs1_data, 32'd203);
    chk("t2 imm", ex_imm, 32'd5);
    chk("t2 busy3", 32'(dut.busy_q[3]), 32'd0);
    chk("t2 busy4", 32'(dut.busy_q[4]), 32'd1);
    wb_valid = 1'b0;

    // Backpressure: hold three cycles, then drain and accept together
    instr = r_ins(5'd2, 5'd1, 5'd6); ex_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t3 stall", 32'(last_ready), 32'd0);
      chk("t3 hold imm", ex_imm, 32'd5);
      chk("t3 hold rd", 32'(ex_rd), 32'd4);
    end
    ex_ready = 1'b1;
    cycle();
    chk("t3 accept", 32'(last_ready), 32'd1);
    chk("t3 rd", 32'(ex_rd), 32'd6);

    // x0 as destination and source
    instr = i_ins(12'd7, 5'd0, 5'd0);
    cycle();
    chk("t4 rd zero", 32'(ex_rd), 32'd0);
    chk("t4 busy0", 32'(dut.busy_q[0]), 32'd0);
    instr = r_ins(5'd0, 5'd0, 5'd1);
    cycle();
    chk("t4 no stall", 32'(last_ready), 32'd1);
    chk("t4 rs1 zero", ex_rs1_data, 32'd0);
    chk("t4 rs2 zero", ex_rs2_data, 32'd0);

    // Writeback of x5 coincident with a new write to x5: busy stays set
    instr = i_ins(12'd1, 5'd0, 5'd5);
    cycle();
    instr = {20'h12345, 5'd5, T_LUI}; wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hCAFE;
    cycle();
    chk("t5 busy5", 32'(dut.busy_q[5]), 32'd1);
    chk("t5 imm", ex_imm, 32'h12345000);
    wb_valid = 1'b0;

    // Reset while FULL with x7 pending
    instr = i_ins(12'd3, 5'd0, 5'd7);
    cycle();
    chk("t6 busy7 pre", 32'(dut.busy_q[7]), 32'd1);
    ex_ready = 1'b0; instr_valid = 1'b0; reset = 1'b0;
    cycle();
    chk("t6 ex_valid", 32'(ex_valid), 32'd0);
    chk("t6 busy", dut.busy_q, 32'd0);
    chk("t6 ex_rd", 32'(ex_rd), 32'd0);
    reset = 1'b1;
    cycle();
    chk("t6 ready", 32'(last_ready), 32'd1);

    // Randomized traffic on a small register window to provoke hazards
    for (int k = 0; k < 600; k++) begin
      reset = ($urandom_range(0, 99) != 0);
      w = $urandom;
      w[6:0]   = pick_op(int'($urandom_range(0, 9)));
      w[11:7]  = 5'($urandom_range(0, 7));
      w[19:15] = 5'($urandom_range(0, 7));
      w[24:20] = 5'($urandom_range(0, 7));
      instr = w;
      instr_valid = ($urandom_range(0, 3) != 0);
      ex_ready = ($urandom_range(0, 3) != 0);
      busy_list.delete();
      for (int r = 1; r < 32; r++) if (m_busy[r]) busy_list.push_back(5'(r));
      wb_data = $urandom;
      if (busy_list.size() > 0 && $urandom_range(0, 1) == 1) begin
        wb_valid = 1'b1;
        wb_rd = busy_list[$urandom_range(0, busy_list.size() - 1)];
      end else begin
        wb_valid = ($urandom_range(0, 7) == 0);
        wb_rd = 5'($urandom_range(0, 7));
      end
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
